lbdr_input_fifo: RTL
====================

# lbdr_input_fifo

Per-input-port flit buffer that sits directly upstream of the LBDR routing stage in each router input channel. It accepts flits from the neighbouring router (or local core) under credit-based flow control and stores them in a circular buffer. It presents the head flit first-word-fall-through, with `empty`, `flit_id` and `dst_addr` already split out so the routing stage consumes them directly. Each pop returns one credit upstream, and a write into a full buffer is trapped in a sticky error flag.

## Interface

- `DATA_WIDTH`, 32: flit width in bits; must be ≥ 7.
- `DEPTH`, 4: buffer entries; power of two, ≥ 2.
- `PTR_W`, $clog2(DEPTH): pointer width (derived, do not override).
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high; clears all state immediately.
- `valid_in` in 1: upstream flit present on `data_in` this cycle.
- `data_in` in DATA_WIDTH: incoming flit.
- `rd_en` in 1: pop request from the downstream allocator/crossbar.
- `data_out` out DATA_WIDTH: head flit (FWFT), all-zero when empty.
- `flit_id` out 3: `data_out[DATA_WIDTH-1:DATA_WIDTH-3]`; encodings are `` `HEADER ``/`` `BODY ``/`` `TAIL `` from parameters.sv.
- `dst_addr` out 4: `data_out[3:0]` ({y[1:0], x[1:0]}), valid when `flit_id` == `` `HEADER ``.
- `empty` out 1: no flit stored.
- `full` out 1: DEPTH flits stored.
- `credit_out` out 1: one-cycle pulse per flit popped.
- `overflow_err` out 1: sticky; a write was attempted while full.

## Operation

- State:
  - `mem[DEPTH]`
  - `wr_ptr`, `rd_ptr` (PTR_W bits, wrap modulo DEPTH)
  - `count` (PTR_W+1 bits)
  - `credit_out` register
  - `overflow_err` register
- Write:
  - Accepted when `valid_in` && !`full`.
  - `mem[wr_ptr]` <= `data_in`, then `wr_ptr` increments.
- Read:
  - Accepted when `rd_en` && !`empty`.
  - `rd_ptr` increments.
  - The entry is zeroed in the same edge, so `data_out` is 0 whenever empty.
- Count update:
  - Write only: +1.
  - Read only: −1.
  - Both accepted: unchanged, both pointers advance.
- `empty` = (`count` == 0); `full` = (`count` == DEPTH). Both are pure decodes of registered `count`, with no combinational path from inputs.
- `data_out` = `mem[rd_ptr]`, combinational from registers. `flit_id` and `dst_addr` are bit slices of `data_out`.
- Boundary cases:
  - **Empty, valid_in && rd_en:** the write is accepted and the read is ignored. `count` becomes 1 and no credit is returned.
  - **Full, valid_in && rd_en:** the read is accepted and the write is dropped. `overflow_err` is set and `count` becomes DEPTH−1. Same-cycle pass-through into a full buffer is not supported.
  - **Full, valid_in only:** the flit is dropped, `overflow_err` <= 1 and stays set until `rst`. Buffer contents are unchanged.
  - **rd_en while empty:** no effect, and no credit is returned.
  - **Pointer wrap:** DEPTH−1 → 0 with no gap; ordering is strictly FIFO across the wrap.
- The block does not interpret packet framing. Header/body/tail order is passed through unchanged; the routing stage latches direction on `` `HEADER ``.

## Timing

- Reset values, applied asynchronously when `rst` rises and held while high:
  - `wr_ptr` = `rd_ptr` = `count` = 0
  - all `mem` = 0
  - `empty` = 1, `full` = 0
  - `data_out` = 0, `flit_id` = 0, `dst_addr` = 0
  - `credit_out` = 0, `overflow_err` = 0
- Write-to-visible latency: a flit written at edge N appears on `data_out` and `empty` falls immediately after edge N (0-cycle FWFT).
- Pop: with `rd_en` high before edge N, the next entry (or 0) is on `data_out` after edge N.
- `credit_out`: registered, high for exactly the cycle after each accepted pop. Back-to-back pops give a continuous high.
- Reset mid-operation: all stored flits are discarded, and a `credit_out` pulse in flight is cancelled. Upstream re-initialises its credit counter to DEPTH on the same `rst`.
- Throughput: one write and one read per cycle sustained when not empty/full.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle with 2 flits stored → `empty`=1, `count`=0, `data_out`=0 and `credit_out`=0 before the next edge.
- **FWFT header:** write 32'h2000_000E (`flit_id`=3'b001 = `` `HEADER ``, dst=4'hE) → the next cycle shows `empty`=0, `flit_id`=1 and `dst_addr`=4'hE, with no read needed.
- **Fill and drain:** write 4 flits (header, 2 body, tail) → `full`=1. Pop 4 with `rd_en` held → flits come out in order and `credit_out` is high for 4 consecutive cycles, each one cycle after its pop. The buffer then shows `empty`=1 and `data_out`=0.
- **Overflow:** while full, `valid_in`=1 with 32'hDEAD_BEEF and no read → `overflow_err`=1 and stays 1. Contents are unchanged, and 4 subsequent pops never return DEAD_BEEF.
- **Simultaneous:**
  - Empty with `valid_in` && `rd_en` → `count`=1 and no credit.
  - 2 stored with both asserted → `count` stays 2, one credit is returned, and order is preserved.
- **Wrap:** 10 interleaved write/read cycles so pointers wrap twice → the output sequence equals the input sequence and `count` never exceeds 4.

Source files
------------

// File: rtl/lbdr_input_fifo_if.sv
// lbdr_input_fifo_if: upstream flit/credit and downstream pop/head-flit signals of one router input channel
interface lbdr_input_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic [2:0]            flit_id;
   logic [3:0]            dst_addr;
   logic                  empty;
   logic                  full;
   logic                  credit_out;
   logic                  overflow_err;
   modport master (
      output valid_in, data_in, rd_en,
      input  data_out, flit_id, dst_addr, empty, full, credit_out, overflow_err
   );
   modport slave (
      input  valid_in, data_in, rd_en,
      output data_out, flit_id, dst_addr, empty, full, credit_out, overflow_err
   );
endinterface

// File: rtl/lbdr_input_fifo.sv
// lbdr_input_fifo: credit-flow circular flit buffer with first-word-fall-through head feeding LBDR routing
module lbdr_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   lbdr_input_fifo_if.slave fifo_if
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]        count_q, count_d;
   logic                  credit_q, overflow_q;
   logic                  empty, full, wr_acc, rd_acc;
   assign empty   = count_q == '0;
   assign full    = count_q == (PTR_W+1)'(DEPTH);
   assign wr_acc  = fifo_if.valid_in && !full;
   assign rd_acc  = fifo_if.rd_en && !empty;
   assign count_d = count_q + (PTR_W+1)'(wr_acc) - (PTR_W+1)'(rd_acc);
   // Popped entries are cleared so the head reads as zero whenever the buffer is empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_acc) mem_q[wr_ptr_q] <= fifo_if.data_in;
         if (rd_acc) mem_q[rd_ptr_q] <= '0;
         wr_ptr_q   <= wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
         rd_ptr_q   <= rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
         count_q    <= count_d;
         credit_q   <= rd_acc;
         overflow_q <= overflow_q || (fifo_if.valid_in && full);
      end
   end
   assign fifo_if.data_out     = mem_q[rd_ptr_q];
   assign fifo_if.flit_id      = fifo_if.data_out[DATA_WIDTH-1:DATA_WIDTH-3];
   assign fifo_if.dst_addr     = fifo_if.data_out[3:0];
   assign fifo_if.empty        = empty;
   assign fifo_if.full         = full;
   assign fifo_if.credit_out   = credit_q;
   assign fifo_if.overflow_err = overflow_q;
endmodule
